debug_tx_arbiter: RTL
=====================

DEBUG_TX_ARBITER -- requirements
Module: debug_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of message requesters (2..8).
REQ-002 SHALL have port clock  input  1: sole clock, all logic on posedge.
REQ-003 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-004 SHALL have port req  input  NUM_REQ: per-requester level request to send one message.
REQ-005 SHALL have port reqAck  output  NUM_REQ: one-cycle pulse to the requester whose message completed.
REQ-006 SHALL have port grant  output  NUM_REQ: one-hot owner of the transmitter; all-zero when idle.
REQ-007 SHALL have port reqMsgType  input  8*NUM_REQ: packed message type, slice i for requester i.
REQ-008 SHALL have port reqMsgLen  input  8*NUM_REQ: packed payload length, slice i for requester i.
REQ-009 SHALL have port reqMsgData  input  8*NUM_REQ: packed payload byte at reqDataIndex, slice i for requester i.
REQ-010 SHALL have port reqDataIndex  output  8: payload index, broadcast to all requesters.
REQ-011 SHALL have port reqDataLoad  output  NUM_REQ: data-load strobe, routed only to the granted requester.
REQ-012 SHALL have ports txMsgType, txMsgLen, txMsgData  output  8 each: to the debug protocol transmitter.
REQ-013 SHALL have ports txMsgDataIndex  input  8 and txMsgDataLoad  input  1: from the transmitter.
REQ-014 SHALL have ports send  output  1 and sendComplete  input  1: transmitter start and done handshake.

Function
REQ-015 SHALL implement the states IDLE, START, BUSY and DONE.
REQ-016 IDLE: SHALL sample req; when it is nonzero, SHALL register grant for the winner and go to START; otherwise SHALL stay in IDLE.
REQ-017 START: SHALL assert send for exactly one cycle, then go to BUSY; send SHALL be 0 in every other state.
REQ-018 BUSY: SHALL hold grant; on sendComplete=1, SHALL go to DONE.
REQ-019 DONE: SHALL pulse reqAck for the granted requester, update the round-robin pointer to that index, clear grant and return to IDLE.
REQ-020 Minimum gap from sendComplete to the next send SHALL be 2 cycles, so the transmitter is back in its wait state before the next start.
REQ-021 Arbitration SHALL be round-robin: the search starts at index (last+1) mod NUM_REQ; after reset, last = NUM_REQ-1, so requester 0 is searched first.
REQ-022 txMsgType, txMsgLen and txMsgData SHALL be combinational muxes of the granted slice; they SHALL be 0 when grant is 0.
REQ-023 reqDataIndex SHALL be txMsgDataIndex passed through combinationally.
REQ-024 reqDataLoad[i] SHALL equal txMsgDataLoad AND grant[i], so the requester's data byte is valid in the same cycle as the load.
REQ-025 A granted requester SHALL hold type, length and data stable until its reqAck; the arbiter does not latch them.
REQ-026 req deasserted during BUSY SHALL be ignored; the transfer SHALL complete and reqAck SHALL still pulse.
REQ-027 sendComplete arriving in IDLE, START or DONE SHALL be ignored.
REQ-028 A zero-length message SHALL follow the same sequence with no reqDataLoad activity.
REQ-029 A requester that holds req across its reqAck SHALL be re-eligible only in the next IDLE, under the normal round-robin order.

Reset
REQ-030 On reset=1, the following SHALL be set at the next edge:
- state = IDLE
- grant = 0
- reqAck = 0
- send = 0
- round-robin pointer = NUM_REQ-1
REQ-031 Reset during BUSY SHALL abandon the transfer with no reqAck pulse.
REQ-032 The system SHALL assert reset only while the transmitter is idle, because the transmitter itself has no reset.

Configuration
REQ-033 With DEBUG_TX_PRIORITY_EN defined, requester 0 SHALL win any IDLE arbitration in which req[0]=1; requesters 1..NUM_REQ-1 SHALL round-robin among themselves.
REQ-034 Without DEBUG_TX_PRIORITY_EN, all requesters SHALL share pure round-robin as in REQ-021.

Verification
REQ-035 Single request: req=4'b0100, type 0x21, len 3 -> grant=0100 one cycle later, one send pulse, 3 reqDataLoad[2] strobes, reqAck[2] pulse one cycle after sendComplete.
REQ-036 Contention: req=4'b1111 held -> grant order 0,1,2,3,0; exactly one reqAck per message.
REQ-037 Priority (macro defined): req=4'b1110 then req[0] set during BUSY of requester 1 -> next grant is 0, then 2; macro undefined -> next grant is 2.
REQ-038 Zero length: len 0 -> send pulse, no reqDataLoad, reqAck issued; txMsgData stays 0 once grant clears.
REQ-039 Reset in BUSY: reset for 1 cycle -> grant=0, no reqAck; stray sendComplete in IDLE ignored; next request served starting at requester 0.
REQ-040 Back-to-back: req[1] held -> send pulses separated by at least 2 cycles after each sendComplete.

Source files
------------

// File: rtl/debug_tx_arbiter.sv
// ============================================================================
// Module   : debug_tx_arbiter
// Purpose  : Round-robin arbiter granting message requesters access to a
//            single debug protocol transmitter. Define DEBUG_TX_PRIORITY_EN
//            to give requester 0 strict priority over the others.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   reqAck,
  output logic [NUM_REQ-1:0]   grant,
  input  logic [8*NUM_REQ-1:0] reqMsgType,
  input  logic [8*NUM_REQ-1:0] reqMsgLen,
  input  logic [8*NUM_REQ-1:0] reqMsgData,
  output logic [7:0]           reqDataIndex,
  output logic [NUM_REQ-1:0]   reqDataLoad,
  output logic [7:0]           txMsgType,
  output logic [7:0]           txMsgLen,
  output logic [7:0]           txMsgData,
  input  logic [7:0]           txMsgDataIndex,
  input  logic                 txMsgDataLoad,
  output logic                 send,
  input  logic                 sendComplete
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_send;
  logic [IW-1:0]      r_last;
  logic [IW-1:0]      r_gidx;

  logic [IW-1:0]      w_win_idx;
  logic               w_win_valid;
  logic [IW-1:0]      w_cand;
  logic [7:0]         w_type;
  logic [7:0]         w_len;
  logic [7:0]         w_data;

  // Winner search begins just after the last served requester.
  always_comb begin
    w_win_idx   = '0;
    w_win_valid = 1'b0;
    w_cand      = '0;
`ifdef DEBUG_TX_PRIORITY_EN
    if (req[0]) begin
      w_win_valid = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ - 1; i++) begin
        w_cand = IW'(((int'(r_last) + i) % (NUM_REQ - 1)) + 1);
        if (!w_win_valid && req[w_cand]) begin
          w_win_valid = 1'b1;
          w_win_idx   = w_cand;
        end
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = IW'((int'(r_last) + 1 + i) % NUM_REQ);
      if (!w_win_valid && req[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ack   <= '0;
      r_send  <= 1'b0;
      r_last  <= IW'(NUM_REQ - 1);
      r_gidx  <= '0;
    end else begin
      r_ack  <= '0;
      r_send <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
            r_gidx  <= w_win_idx;
            r_send  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (sendComplete) begin
            r_ack   <= r_grant;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_grant <= '0;
`ifdef DEBUG_TX_PRIORITY_EN
          // Requester 0 sits outside the rotation, so its grants leave the pointer alone.
          if (r_gidx != '0) r_last <= r_gidx;
`else
          r_last <= r_gidx;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_type = '0;
    w_len  = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_type = w_type | reqMsgType[i*8 +: 8];
        w_len  = w_len  | reqMsgLen[i*8 +: 8];
        w_data = w_data | reqMsgData[i*8 +: 8];
      end
    end
  end

  assign grant        = r_grant;
  assign reqAck       = r_ack;
  assign send         = r_send;
  assign txMsgType    = w_type;
  assign txMsgLen     = w_len;
  assign txMsgData    = w_data;
  assign reqDataIndex = txMsgDataIndex;
  assign reqDataLoad  = r_grant & {NUM_REQ{txMsgDataLoad}};

endmodule

`default_nettype wire
